rv_regfile_sb: RTL and testbench

- Parametrised integer register file with a built-in scoreboard for the pipelined RISC-V core.
- Provides two combinational read ports and one synchronous write (writeback) port.
- Register 0 is hardwired to zero; writeback data is optionally bypassed to the read ports.
- Tracks a pending-write bit per register and raises a stall when an issuing instruction hits a RAW or WAW hazard.
- Sits between decode/issue and writeback, replacing the single-cycle register file.

---
 rtl/rv_regfile_sb.sv | 117 +++++++++++
 tb/tb_rv_regfile_sb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: integer register file with a per-register pending-write
// scoreboard. It has two combinational read ports, one writeback port, and
// stall generation for RAW/WAW hazards at issue.
module rv_regfile_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_valid,
  input  logic            iss_use1,
  input  logic            iss_use2,
  input  logic            iss_wen,
  input  logic [AW-1:0]   iss_rd,
  output logic            stall,
  output logic [NREG-1:0] pend_vec,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic [AW:0]     r_cnt;

  logic            w_wr_drop;
  logic            w_byp1;
  logic            w_byp2;
  logic            w_raw1;
  logic            w_raw2;
  logic            w_waw;
  logic            w_stall;
  logic            w_set;
  logic [NREG-1:0] w_pend_nxt;
  logic [AW:0]     w_cnt_nxt;

  // Writes to x0 are discarded so it always reads back as zero.
  assign w_wr_drop = ZERO_X0 && (wa == '0);

  // Same-cycle writeback forwarding matches per read port.
  assign w_byp1 = BYPASS && we && (wa == ra1);
  assign w_byp2 = BYPASS && we && (wa == ra2);

  // Combinational read ports: x0, then forwarded writeback, then array.
  always_comb begin
    rd1 = r_regs[ra1];
    rd2 = r_regs[ra2];
    if (w_byp1) rd1 = wd;
    if (w_byp2) rd2 = wd;
    if (ZERO_X0 && (ra1 == '0)) rd1 = '0;
    if (ZERO_X0 && (ra2 == '0)) rd2 = '0;
    if (rst) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  // Hazard detection. A WAW hazard is cleared when the older producer
  // retires in this same cycle, even when forwarding is disabled.
  assign w_raw1  = iss_use1 && r_pend[ra1] && !w_byp1;
  assign w_raw2  = iss_use2 && r_pend[ra2] && !w_byp2;
  assign w_waw   = iss_wen && r_pend[iss_rd] && !(we && (wa == iss_rd));
  assign w_stall = iss_valid && (w_raw1 || w_raw2 || w_waw);
  assign stall   = w_stall && !rst;

  assign w_set = iss_valid && iss_wen && !w_stall &&
                 !(ZERO_X0 && (iss_rd == '0));

  // Next pending vector. The set is applied after the clear, so a new
  // producer wins over a retiring one on the same register.
  always_comb begin
    w_pend_nxt = r_pend;
    if (we) w_pend_nxt[wa] = 1'b0;
    if (w_set) w_pend_nxt[iss_rd] = 1'b1;
    if (ZERO_X0) w_pend_nxt[0] = 1'b0;
  end

  // Population count of the next pending vector, registered with it.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_pend_nxt[i]);
    end
  end

  // Scoreboard state: the pending bits and their count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Register array. Reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (we && !w_wr_drop) begin
      r_regs[wa] <= wd;
    end
  end

  assign pend_vec = r_pend;
  assign pend_cnt = r_cnt;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed testbench for rv_regfile_sb. It drives two instances, one with
// forwarding enabled and one with it disabled, from the same inputs.
module tb_rv_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   ra1, ra2, wa, iss_rd;
  logic [XLEN-1:0] wd;
  logic            we, iss_valid, iss_use1, iss_use2, iss_wen;

  logic [XLEN-1:0] rd1, rd2, rd1_nb, rd2_nb;
  logic            stall, stall_nb;
  logic [NREG-1:0] pend_vec, pend_vec_nb;
  logic [AW:0]     pend_cnt, pend_cnt_nb;

  int n_tests = 0;
  int n_fail  = 0;

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b1), .ZERO_X0(1'b1)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_use1(iss_use1),
    .iss_use2(iss_use2), .iss_wen(iss_wen), .iss_rd(iss_rd), .stall(stall),
    .pend_vec(pend_vec), .pend_cnt(pend_cnt)
  );

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b0), .ZERO_X0(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_use1(iss_use1),
    .iss_use2(iss_use2), .iss_wen(iss_wen), .iss_rd(iss_rd), .stall(stall_nb),
    .pend_vec(pend_vec_nb), .pend_cnt(pend_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare an observed value against the expected one and count it.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; wa = '0; wd = '0;
    iss_valid = 0; iss_use1 = 0; iss_use2 = 0; iss_wen = 0; iss_rd = '0;
  endtask

  // Stop the run if it ever runs far beyond its expected length.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; ra1 = '0; ra2 = '0;
    idle();
    step(); step();
    rst = 0;

    // Reset: a written value and a pending bit are both discarded.
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    step();
    idle(); ra1 = 5; #1;
    chk("wr_x5", rd1, 32'hDEADBEEF);
    iss_valid = 1; iss_wen = 1; iss_rd = 4;
    step();
    idle(); #1;
    chk("pend_x4", pend_vec, 64'h10);
    chk("cnt_x4", pend_cnt, 1);
    rst = 1; iss_valid = 1; iss_wen = 1; iss_rd = 4; #1;
    chk("rst_rd1", rd1, 0);
    chk("rst_stall", stall, 0);
    step();
    rst = 0; idle(); #1;
    chk("post_rst_x5", rd1, 0);
    chk("post_rst_pend", pend_vec, 0);
    chk("post_rst_cnt", pend_cnt, 0);

    // x0 handling: writes are dropped and x0 never becomes pending.
    we = 1; wa = 0; wd = 32'h1234; ra1 = 0; #1;
    chk("x0_byp", rd1, 0);
    step();
    idle(); #1;
    chk("x0_rd", rd1, 0);
    iss_valid = 1; iss_wen = 1; iss_rd = 0;
    step();
    idle(); #1;
    chk("x0_pend", pend_vec, 0);

    // Forwarding: same cycle with BYPASS=1, next cycle with BYPASS=0.
    we = 1; wa = 7; wd = 32'hA5A5A5A5; ra2 = 7; #1;
    chk("byp_rd2", rd2, 32'hA5A5A5A5);
    chk("nb_rd2_old", rd2_nb, 0);
    step();
    idle(); #1;
    chk("nb_rd2_new", rd2_nb, 32'hA5A5A5A5);
    chk("byp_rd2_hold", rd2, 32'hA5A5A5A5);

    // RAW: a pending x3 stalls a reader until the writeback arrives.
    iss_valid = 1; iss_wen = 1; iss_rd = 3;
    step();
    idle(); #1;
    chk("raw_pend", pend_vec, 64'h8);
    chk("raw_cnt", pend_cnt, 1);
    iss_valid = 1; iss_use1 = 1; ra1 = 3; iss_wen = 1; iss_rd = 10; #1;
    chk("raw_stall", stall, 1);
    step();
    chk("raw_pend_hold", pend_vec, 64'h8);
    we = 1; wa = 3; wd = 32'hCAFEF00D; #1;
    chk("raw_byp_stall", stall, 0);
    chk("raw_byp_rd1", rd1, 32'hCAFEF00D);
    chk("raw_nb_stall", stall_nb, 1);
    step();
    idle(); #1;
    chk("raw_after", pend_vec, 64'h400);
    we = 1; wa = 10; wd = 32'h0;
    step();
    idle(); #1;
    chk("clr_x10", pend_cnt, 0);

    // WAW, and a set and clear on the same register in the same cycle.
    iss_valid = 1; iss_wen = 1; iss_rd = 9;
    step();
    #1;
    chk("waw_stall", stall, 1);
    we = 1; wa = 9; wd = 32'h99; #1;
    chk("waw_wb_stall", stall, 0);
    step();
    idle(); #1;
    chk("waw_pend", pend_vec, 64'h200);
    chk("waw_cnt", pend_cnt, 1);
    we = 1; wa = 9; wd = 32'h99;
    step();
    idle(); #1;
    chk("waw_clr", pend_cnt, 0);

    // Count saturation: fill x1..x31, then retire all of them.
    for (int i = 1; i < NREG; i++) begin
      iss_valid = 1; iss_wen = 1; iss_rd = AW'(i);
      step();
    end
    idle(); #1;
    chk("full_cnt", pend_cnt, 31);
    chk("full_vec", pend_vec, 64'hFFFFFFFE);
    for (int i = 1; i < NREG; i++) begin
      we = 1; wa = AW'(i); wd = XLEN'(i);
      step();
    end
    idle(); #1;
    chk("empty_cnt", pend_cnt, 0);
    chk("empty_vec", pend_vec, 0);
    ra1 = 17; #1;
    chk("wb_x17", rd1, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
